mem_port_arbiter: RTL

- Round-robin arbiter that shares the unified instruction/data memory between two requesters: the multicycle core (port 0) and the program loader/debug port (port 1).
- Each granted request becomes one memory transaction. The memory may add any number of wait states.
- Sits between the core's memory address/write-data path and the memory macro.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (port 0) and the loader/debug port (port 1).
// Optional wait-state timeout with error response: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [DATA_W/8-1:0] p0_be,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_ack,
  output logic [DATA_W-1:0]   p0_rdata,
  output logic                p0_err,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [DATA_W/8-1:0] p1_be,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_ack,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic                p1_err,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                grant_id,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_id_q, grant_id_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                pick;
  logic                timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  // Counter sits at zero outside ISSUE, so it is clear on every entry.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ISSUE && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  assign timeout_hit = (state_q == ISSUE) && !mem_ready &&
                       (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign err_d       = timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign p0_err = err_q && (state_q == RESP) && !grant_id_q;
  assign p1_err = err_q && (state_q == RESP) &&  grant_id_q;
`else
  assign timeout_hit = 1'b0;
  assign p0_err      = 1'b0;
  assign p1_err      = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    pick         = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // A tie goes to the port that did not win last time.
          pick         = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          grant_id_d   = pick;
          last_grant_d = pick;
          mem_we_d     = pick ? p1_we    : p0_we;
          mem_be_d     = pick ? p1_be    : p0_be;
          mem_addr_d   = pick ? p1_addr  : p0_addr;
          mem_wdata_d  = pick ? p1_wdata : p0_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (!mem_we_q) begin
            if (grant_id_q) p1_rdata_d = mem_rdata;
            else            p0_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign mem_valid = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign p0_ack    = (state_q == RESP) && !grant_id_q;
  assign p1_ack    = (state_q == RESP) &&  grant_id_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign grant_id  = grant_id_q;

endmodule
